// File: rtl/cache_fill_ctrl.sv
// Cache-line fill controller: on a miss, reads every word of the line from memory.
// The first word read is the missed word (critical-word-first) or word 0. Each
// returned word is steered into the data array, and the tag/valid entry is written
// on the final beat.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned CWF    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_detected,
    input  logic [ADDR_W-1:0]            miss_address,
    input  logic                         memory_data_valid,
    input  logic [DATA_W-1:0]            memory_data,
    output logic                         fsm_busy,
    output logic                         memory_read,
    output logic [ADDR_W-1:0]            memory_address,
    output logic                         write_data_array,
    output logic                         write_tag_array,
    output logic [$clog2(WORDS)-1:0]     word_num,
    output logic                         critical_word_valid,
    output logic [DATA_W-1:0]            critical_word_data
);

    localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W  = $clog2(WORDS);
    localparam int unsigned OFF_W  = IDX_W + BYTE_W;
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'(1) << OFF_W) - 64'(1));

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   crit_q;
    logic [IDX_W-1:0]   miss_idx;

    assign miss_idx = miss_address[OFF_W-1:BYTE_W];

    // Fill sequencing: capture the line on a miss, advance one word per valid beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            crit_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss_detected) begin
                        base_q  <= miss_address & ~OFF_MASK;
                        crit_q  <= miss_idx;
                        idx_q   <= (CWF != 0) ? miss_idx : '0;
                        cnt_q   <= '0;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (memory_data_valid) begin
                        // Power-of-two line, so the increment wraps within the line.
                        idx_q <= idx_q + 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Request and write strobes; writes follow memory_data_valid in the same cycle.
    always_comb begin
        fsm_busy            = 1'b0;
        memory_read         = 1'b0;
        memory_address      = '0;
        write_data_array    = 1'b0;
        write_tag_array     = 1'b0;
        word_num            = '0;
        critical_word_valid = 1'b0;
        critical_word_data  = '0;
        unique case (state_q)
            StIdle: begin
                fsm_busy = miss_detected;
            end
            StFill: begin
                fsm_busy       = 1'b1;
                memory_read    = 1'b1;
                memory_address = base_q | (ADDR_W'(idx_q) << BYTE_W);
                word_num       = idx_q;
                if (memory_data_valid) begin
                    write_data_array    = 1'b1;
                    write_tag_array     = (cnt_q == LAST_CNT);
                    critical_word_valid = (idx_q == crit_q);
                    critical_word_data  = (idx_q == crit_q) ? memory_data : '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed table vectors for the documented sequences,
// then randomized fills checked against a line-level reference model.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic [15:0] maddr;
    logic        mvalid;
    logic [15:0] mdata;

    // Index 0: CWF=1 instance, index 1: CWF=0 instance; both share the inputs.
    logic [1:0]  busy_v, rd_v, wr_v, tag_v, cv_v;
    logic [15:0] addr_v [2];
    logic [15:0] cd_v   [2];
    logic [2:0]  wn_v   [2];

    logic        m32_miss;
    logic [31:0] m32_addr;
    logic        m32_valid;
    logic [31:0] m32_data;
    logic        busy_c, rd_c, wr_c, tag_c, cv_c;
    logic [31:0] addr_c, cd_c;
    logic [1:0]  wn_c;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .CWF(1)) dut_a (
        .clk(clk), .rst(rst), .miss_detected(miss), .miss_address(maddr),
        .memory_data_valid(mvalid), .memory_data(mdata), .fsm_busy(busy_v[0]),
        .memory_read(rd_v[0]), .memory_address(addr_v[0]), .write_data_array(wr_v[0]),
        .write_tag_array(tag_v[0]), .word_num(wn_v[0]), .critical_word_valid(cv_v[0]),
        .critical_word_data(cd_v[0])
    );

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .CWF(0)) dut_b (
        .clk(clk), .rst(rst), .miss_detected(miss), .miss_address(maddr),
        .memory_data_valid(mvalid), .memory_data(mdata), .fsm_busy(busy_v[1]),
        .memory_read(rd_v[1]), .memory_address(addr_v[1]), .write_data_array(wr_v[1]),
        .write_tag_array(tag_v[1]), .word_num(wn_v[1]), .critical_word_valid(cv_v[1]),
        .critical_word_data(cd_v[1])
    );

    cache_fill_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS(4), .CWF(1)) dut_c (
        .clk(clk), .rst(rst), .miss_detected(m32_miss), .miss_address(m32_addr),
        .memory_data_valid(m32_valid), .memory_data(m32_data), .fsm_busy(busy_c),
        .memory_read(rd_c), .memory_address(addr_c), .write_data_array(wr_c),
        .write_tag_array(tag_c), .word_num(wn_c), .critical_word_valid(cv_c),
        .critical_word_data(cd_c)
    );

    // Reference model: one line-fill descriptor per 16-bit instance.
    bit        m_busy  [2];
    int        m_base  [2];
    int        m_crit  [2];
    int        m_start [2];
    int        m_done  [2];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_base[i] = 0; m_crit[i] = 0; m_start[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            int  w;
            bit  e_busy, e_rd, e_wr, e_tag, e_cv;
            int  e_addr, e_wn, e_cd;
            w = (m_start[i] + m_done[i]) % 8;
            e_busy = m_busy[i] ? 1'b1 : miss;
            e_rd   = m_busy[i];
            e_addr = m_busy[i] ? ((m_base[i] + 2 * w) % 65536) : 0;
            e_wn   = m_busy[i] ? w : 0;
            e_wr   = m_busy[i] && mvalid;
            e_tag  = m_busy[i] && mvalid && (m_done[i] == 7);
            e_cv   = m_busy[i] && mvalid && (w == m_crit[i]);
            e_cd   = e_cv ? int'(mdata) : 0;
            chk($sformatf("busy%0d", i), busy_v[i], e_busy);
            chk($sformatf("read%0d", i), rd_v[i], e_rd);
            chk($sformatf("addr%0d", i), addr_v[i], e_addr);
            chk($sformatf("word_num%0d", i), wn_v[i], e_wn);
            chk($sformatf("wr_data%0d", i), wr_v[i], e_wr);
            chk($sformatf("wr_tag%0d", i), tag_v[i], e_tag);
            chk($sformatf("crit_valid%0d", i), cv_v[i], e_cv);
            chk($sformatf("crit_data%0d", i), cd_v[i], e_cd);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                if (miss) begin
                    m_busy[i]  = 1;
                    m_base[i]  = int'(maddr) & 16'hFFF0;
                    m_crit[i]  = (int'(maddr) / 2) % 8;
                    m_start[i] = (i == 0) ? m_crit[i] : 0;
                    m_done[i]  = 0;
                end
            end else if (mvalid) begin
                m_done[i]++;
                if (m_done[i] == 8) m_busy[i] = 0;
            end
        end
    endtask

    // Drive inputs at the falling edge, then check combinational outputs.
    task automatic drive(input bit mi, input logic [15:0] ma, input bit v,
                         input bit m32m, input logic [31:0] m32a, input bit m32v);
        @(negedge clk);
        miss = mi; maddr = ma; mvalid = v; mdata = 16'($urandom);
        m32_miss = m32m; m32_addr = m32a; m32_valid = m32v; m32_data = $urandom;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; miss = 0; mvalid = 0; m32_miss = 0; m32_valid = 0;
        #1;
        chk("rst_busy", {busy_v, busy_c}, 0);
        chk("rst_read", {rd_v, rd_c}, 0);
        chk("rst_wr", {wr_v, wr_c, tag_v, tag_c}, 0);
        chk("rst_addr", {addr_v[0], addr_v[1], addr_c}, 0);
        chk("rst_wn", {wn_v[0], wn_v[1], wn_c}, 0);
        chk("rst_crit", {cv_v, cv_c, cd_v[0], cd_v[1], cd_c}, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          wn;
        bit          crit;
        bit          tag;
    } vec_t;

    vec_t t1 [8];
    vec_t t2 [8];
    vec_t t3 [4];

    initial begin
        int gap;
        rst = 1'b0; miss = 0; maddr = 0; mvalid = 0; mdata = 0;
        m32_miss = 0; m32_addr = 0; m32_valid = 0; m32_data = 0;
        model_reset();

        t1[0] = '{32'h1236, 3, 1, 0}; t1[1] = '{32'h1238, 4, 0, 0};
        t1[2] = '{32'h123A, 5, 0, 0}; t1[3] = '{32'h123C, 6, 0, 0};
        t1[4] = '{32'h123E, 7, 0, 0}; t1[5] = '{32'h1230, 0, 0, 0};
        t1[6] = '{32'h1232, 1, 0, 0}; t1[7] = '{32'h1234, 2, 0, 1};
        for (int k = 0; k < 8; k++) t2[k] = '{32'h00A0 + 2 * k, k, k == 7, k == 7};
        t3[0] = '{32'h100C, 3, 1, 0}; t3[1] = '{32'h1000, 0, 0, 0};
        t3[2] = '{32'h1004, 1, 0, 0}; t3[3] = '{32'h1008, 2, 0, 1};

        do_reset();

        // CWF=1, miss 0x1236, valid every cycle.
        drive(1, 16'h1236, 0, 0, 0, 0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk($sformatf("t1_addr[%0d]", k), addr_v[0], t1[k].addr);
            chk($sformatf("t1_wn[%0d]", k), wn_v[0], t1[k].wn);
            chk($sformatf("t1_crit[%0d]", k), cv_v[0], t1[k].crit);
            chk($sformatf("t1_tag[%0d]", k), tag_v[0], t1[k].tag);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_busy_after", busy_v[0], 0);
        tick();

        // CWF=0, miss 0x00AE.
        drive(1, 16'h00AE, 0, 0, 0, 0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk($sformatf("t2_addr[%0d]", k), addr_v[1], t2[k].addr);
            chk($sformatf("t2_wn[%0d]", k), wn_v[1], t2[k].wn);
            chk($sformatf("t2_crit[%0d]", k), cv_v[1], t2[k].crit);
            chk($sformatf("t2_tag[%0d]", k), tag_v[1], t2[k].tag);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0); tick();

        // 32-bit, 4-word line, miss 0x100C.
        drive(0, 0, 0, 1, 32'h0000_100C, 0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            chk($sformatf("t3_addr[%0d]", k), addr_c, t3[k].addr);
            chk($sformatf("t3_wn[%0d]", k), wn_c, t3[k].wn);
            chk($sformatf("t3_crit[%0d]", k), cv_c, t3[k].crit);
            chk($sformatf("t3_cdata[%0d]", k), cd_c, t3[k].crit ? m32_data : 32'h0);
            chk($sformatf("t3_tag[%0d]", k), tag_c, t3[k].tag);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_busy_after", busy_c, 0);
        tick();

        // Reset after 3 beats, then a clean fill at 0x4000.
        drive(1, 16'h2222, 0, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
        do_reset();
        drive(1, 16'h4000, 0, 0, 0, 0); tick();
        for (int k = 0; k < 8; k++) begin drive(0, 0, 1, 0, 0, 0); tick(); end

        // Mid-fill miss at 0xFFF0 ignored; back-to-back miss right after the tag write.
        drive(1, 16'h5554, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(1, 16'hFFF0, 0, 0, 0, 0); tick();
        for (int k = 0; k < 7; k++) begin drive(k == 3, 16'hFFF0, 1, 0, 0, 0); tick(); end
        drive(1, 16'h7A1E, 0, 0, 0, 0); tick();
        for (int k = 0; k < 8; k++) begin drive(0, 0, 1, 0, 0, 0); tick(); end

        // Randomized: miss addresses, 0-5 cycle gaps, stray misses, occasional reset.
        gap = 0;
        for (int c = 0; c < 3000; c++) begin
            bit mi, v;
            logic [15:0] a;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                gap = 0;
            end else begin
                a  = 16'($urandom);
                mi = ($urandom_range(0, 3) != 0);
                v  = (gap == 0);
                if (gap == 0) gap = $urandom_range(0, 5);
                else gap--;
                drive(mi, a, v, 0, 0, 0);
                tick();
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
